// File: rtl/ex_store_buf_pkg.sv
// Shared types and constants for the EX store write buffer.
// The optional feature macro STORE_FWD_EN is consumed in ex_store_buf.sv.
package ex_store_buf_pkg;

  localparam int SB_DEPTH_DEF = 4;
  localparam int SB_WORD_LSB  = 2;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_REQ  = 1'b1
  } sb_state_e;

endpackage

// File: rtl/ex_store_buf_sb_match.sv
// Load-address match against buffered stores: per-entry word-address compare
// and youngest-first select, scanning from wr_ptr-1 backwards.
module sb_match
  import ex_store_buf_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEF,
  parameter int ADDR_W   = 32,
  parameter int PW       = $clog2(SB_DEPTH)
) (
  input  logic [SB_DEPTH-1:0]             vld_i,
  input  logic [SB_DEPTH-1:0][ADDR_W-1:0] addr_i,
  input  logic [PW-1:0]                   wr_ptr_i,
  input  logic [ADDR_W-1:0]               ld_addr_i,
  output logic                            any_match_o,
  output logic [PW-1:0]                   sel_idx_o
);

  logic [SB_DEPTH-1:0] hit;
  logic [PW-1:0]       idx;
  logic                found;

  always_comb begin
    hit = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      hit[i] = vld_i[i] &
               (addr_i[i][ADDR_W-1:SB_WORD_LSB] == ld_addr_i[ADDR_W-1:SB_WORD_LSB]);
    end
  end

  assign any_match_o = |hit;

  // Walk from the most recently written slot towards the oldest; first hit wins.
  always_comb begin
    sel_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = wr_ptr_i - PW'(i + 1);
      if (!found && hit[idx]) begin
        sel_idx_o = idx;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ex_store_buf.sv
// In-order store write buffer between EX and the RIB bus, with load conflict detection.
// Define STORE_FWD_EN to forward the youngest matching store's data instead of flagging a conflict.
module ex_store_buf
  import ex_store_buf_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEF,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_wr_req_i,
  input  logic              ex_wr_en_i,
  input  logic [ADDR_W-1:0] ex_wr_addr_i,
  input  logic [DATA_W-1:0] ex_wr_data_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic              rib_ack_i,
  output logic              rib_req_o,
  output logic              rib_we_o,
  output logic [ADDR_W-1:0] rib_addr_o,
  output logic [DATA_W-1:0] rib_data_o,
  output logic              sb_hold_o,
  output logic              sb_empty_o,
  output logic              ld_conflict_o,
  output logic              fwd_hit_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic              ovf_o
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(SB_DEPTH);

  logic [SB_DEPTH-1:0][ADDR_W-1:0] addr_mem_q;
  logic [SB_DEPTH-1:0][DATA_W-1:0] data_mem_q;
  logic [SB_DEPTH-1:0]             vld_q, vld_d;
  logic [PW-1:0]                   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]                   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic                            ovf_q, ovf_d;
  sb_state_e                       state_q;

  logic          enq_req;
  logic          enq_acc;
  logic          deq;
  logic          full;
  logic          any_match;
  logic [PW-1:0] sel_idx;

  assign full    = (cnt_q == FULL_CNT);
  assign deq     = (state_q == SB_REQ) & rib_ack_i;
  assign enq_req = ex_wr_req_i & ex_wr_en_i;
  // A full buffer still takes a store when the head retires in the same cycle.
  assign enq_acc = enq_req & (~full | deq);

  always_comb begin
    vld_d = vld_q;
    if (deq)     vld_d[rd_ptr_q] = 1'b0;
    if (enq_acc) vld_d[wr_ptr_q] = 1'b1;
    rd_ptr_d = rd_ptr_q + PW'(deq);
    wr_ptr_d = wr_ptr_q + PW'(enq_acc);
    cnt_d    = cnt_q + CW'(enq_acc) - CW'(deq);
    ovf_d    = ovf_q | (enq_req & full & ~deq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SB_IDLE;
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      // Next state follows post-update occupancy, so draining is back-to-back.
      case (state_q)
        SB_IDLE: if (cnt_d != '0) state_q <= SB_REQ;
        SB_REQ:  if (cnt_d == '0) state_q <= SB_IDLE;
        default: state_q <= SB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq_acc) begin
      addr_mem_q[wr_ptr_q] <= ex_wr_addr_i;
      data_mem_q[wr_ptr_q] <= ex_wr_data_i;
    end
  end

  // The head slot cannot change until it is acked, so addr/data stay stable in REQ.
  assign rib_req_o  = (state_q == SB_REQ);
  assign rib_we_o   = rib_req_o;
  assign rib_addr_o = rib_req_o ? addr_mem_q[rd_ptr_q] : '0;
  assign rib_data_o = rib_req_o ? data_mem_q[rd_ptr_q] : '0;
  assign sb_hold_o  = full;
  assign sb_empty_o = (cnt_q == '0) & (state_q == SB_IDLE);
  assign ovf_o      = ovf_q;

  sb_match #(
    .SB_DEPTH (SB_DEPTH),
    .ADDR_W   (ADDR_W),
    .PW       (PW)
  ) u_match (
    .vld_i       (vld_q),
    .addr_i      (addr_mem_q),
    .wr_ptr_i    (wr_ptr_q),
    .ld_addr_i   (ld_addr_i),
    .any_match_o (any_match),
    .sel_idx_o   (sel_idx)
  );

`ifdef STORE_FWD_EN
  assign ld_conflict_o = 1'b0;
  assign fwd_hit_o     = any_match;
  assign fwd_data_o    = any_match ? data_mem_q[sel_idx] : '0;
`else
  logic unused_sel;
  assign unused_sel    = ^sel_idx;
  assign ld_conflict_o = any_match;
  assign fwd_hit_o     = 1'b0;
  assign fwd_data_o    = '0;
`endif

endmodule
